uart_frame_rx: RTL and testbench

Framed-packet decoder behind the UART receiver: consumes the byte stream (`rx_drdy`/`received`) and recovers frames of the form SOF, length, payload, checksum. Validated payload bytes stream out with a per-frame pass/fail verdict for the Bluetooth command logic. Single clock domain; the byte strobe is already synchronous to `clk`.

---
 rtl/uart_frame_pkg.sv | 20 ++
 rtl/uart_frame_rx_gap_timer.sv | 38 +++
 rtl/uart_frame_rx.sv | 134 +++++++++++++
 tb/tb_uart_frame_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared constants and types for the framed-packet decoder behind the UART receiver.
package uart_frame_pkg;

  localparam logic [7:0] SOF = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_CSUM    = 2'd3
  } err_e;

endpackage

// File: rtl/uart_frame_rx_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled and flags expiry so the
// registered error pulse lands exactly TIMEOUT_CYCLES after the last byte.
module gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Expiry is flagged one cycle early because the consumer registers its error pulse.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_frame_rx.sv
// Frame decoder: SOF, LEN, payload, optional CSUM (macro UART_FRAME_CSUM_EN).
// Payload streams out before the verdict; consumers drop buffered bytes on frame_err.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_drdy,
  input  logic [7:0] received,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  output logic       pl_last,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e     state_q;
  err_e       err_code_q;
  logic [7:0] rem_q;
  logic [7:0] pl_data_q;
  logic       pl_valid_q, pl_last_q, done_q, err_q;
  logic       tmo_expired;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0] sum_q;
`endif

  gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .enable  (state_q != ST_IDLE),
    .clear   (rx_drdy),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      err_code_q <= ERR_NONE;
      rem_q      <= 8'd0;
      pl_data_q  <= 8'd0;
      pl_valid_q <= 1'b0;
      pl_last_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef UART_FRAME_CSUM_EN
      sum_q      <= 8'd0;
`endif
    end else begin
      pl_valid_q <= 1'b0;
      pl_last_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      // A byte arriving on the expiry cycle takes priority over the timeout.
      if (rx_drdy) begin
        case (state_q)
          ST_IDLE: begin
            if (received == SOF) state_q <= ST_LEN;
          end
          ST_LEN: begin
            rem_q <= received;
`ifdef UART_FRAME_CSUM_EN
            sum_q <= received;
`endif
            if (received > MAX_LEN_B) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_LEN;
              state_q    <= ST_IDLE;
            end else if (received == 8'd0) begin
`ifdef UART_FRAME_CSUM_EN
              state_q <= ST_CSUM;
`else
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
`endif
            end else begin
              state_q <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            pl_data_q  <= received;
            pl_valid_q <= 1'b1;
            rem_q      <= rem_q - 8'd1;
`ifdef UART_FRAME_CSUM_EN
            sum_q      <= sum_q + received;
`endif
            if (rem_q == 8'd1) begin
              pl_last_q <= 1'b1;
`ifdef UART_FRAME_CSUM_EN
              state_q   <= ST_CSUM;
`else
              done_q    <= 1'b1;
              state_q   <= ST_IDLE;
`endif
            end
          end
`ifdef UART_FRAME_CSUM_EN
          ST_CSUM: begin
            if (8'(sum_q + received) == 8'h00) begin
              done_q <= 1'b1;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_CSUM;
            end
            state_q <= ST_IDLE;
          end
`endif
          default: state_q <= ST_IDLE;
        endcase
      end else if (tmo_expired) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
        state_q    <= ST_IDLE;
      end
    end
  end

  assign pl_data    = pl_data_q;
  assign pl_valid   = pl_valid_q;
  assign pl_last    = pl_last_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q != ST_IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx; expectations adapt to UART_FRAME_CSUM_EN.
module tb_uart_frame_rx;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned T       = 20;
  localparam logic [3:0]  V_DONE  = 4'b1000;

  logic       clk, reset, rx_drdy;
  logic [7:0] received, pl_data;
  logic       pl_valid, pl_last, frame_done, frame_err, busy;
  logic [1:0] err_code, state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [8:0] exp_q[$];
  logic [3:0] exp_v_q[$];
  int         exp_c_q[$];
  logic [8:0] mon_e;
  logic [3:0] mon_v;
  int         mon_c;

  uart_frame_rx #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .rx_drdy(rx_drdy), .received(received),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last),
    .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver tasks (called at a negedge, return at the next negedge)
  task automatic send_byte(input logic [7:0] b);
    rx_drdy  = 1'b1;
    received = b;
    @(negedge clk);
    rx_drdy  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pl(input logic [7:0] b, input logic last);
    exp_q.push_back({last, b});
  endtask

  task automatic expect_v(input logic [3:0] v, input int c);
    exp_v_q.push_back(v);
    exp_c_q.push_back(c);
  endtask

  task automatic end_test(input string tag);
    check_eq({tag, "_pl_left"}, exp_q.size(), 0);
    check_eq({tag, "_v_left"}, exp_v_q.size(), 0);
    exp_q.delete();
    exp_v_q.delete();
    exp_c_q.delete();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (pl_valid) begin
        check_eq("pl_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_eq("pl_last_data", {pl_last, pl_data}, mon_e);
        end
      end
      if (frame_done || frame_err) begin
        check_eq("v_pending", exp_v_q.size() != 0, 1);
        check_eq("busy_at_verdict", busy, 0);
        if (exp_v_q.size() != 0) begin
          mon_v = exp_v_q.pop_front();
          mon_c = exp_c_q.pop_front();
          check_eq("verdict", {frame_done, frame_err, frame_err ? err_code : 2'b00}, mon_v);
          check_eq("verdict_cycle", cyc, mon_c);
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    rx_drdy  = 1'b0;
    received = 8'h00;
    idle(2);
    check_eq("rst_pl_valid", pl_valid, 0);
    check_eq("rst_pl_data", pl_data, 0);
    check_eq("rst_done_err", {frame_done, frame_err}, 0);
    check_eq("rst_err_code", err_code, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_state", state_dbg, 0);
    reset = 1'b0;
    idle(2);

    // t1: good frame 7E 03 11 22 33 97 (03+11+22+33+97 = 0x100)
    expect_pl(8'h11, 0); expect_pl(8'h22, 0); expect_pl(8'h33, 1);
    send_byte(8'h7E);
    check_eq("t1_busy_rise", busy, 1);
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
`ifndef UART_FRAME_CSUM_EN
    expect_v(V_DONE, cyc + 1);
`endif
    send_byte(8'h33);
`ifdef UART_FRAME_CSUM_EN
    expect_v(V_DONE, cyc + 1);
`endif
    send_byte(8'h97);
    idle(3);
    end_test("t1");

    // t2: bad checksum 7E 02 AA BB 00
    expect_pl(8'hAA, 0); expect_pl(8'hBB, 1);
    send_byte(8'h7E); send_byte(8'h02); send_byte(8'hAA);
`ifdef UART_FRAME_CSUM_EN
    send_byte(8'hBB);
    expect_v({2'b01, 2'd3}, cyc + 1);
    send_byte(8'h00);
    idle(3);
    check_eq("t2_err_code", err_code, 3);
`else
    expect_v(V_DONE, cyc + 1);
    send_byte(8'hBB);
    send_byte(8'h00);
    idle(3);
    check_eq("t2_err_code", err_code, 0);
`endif
    end_test("t2");

    // t3: length overflow, then empty frame 7E 00 00
    send_byte(8'h7E);
    expect_v({2'b01, 2'd1}, cyc + 1);
    send_byte(8'h11);
    check_eq("t3_busy_fall", busy, 0);
    send_byte(8'h7E);
`ifdef UART_FRAME_CSUM_EN
    send_byte(8'h00);
    expect_v(V_DONE, cyc + 1);
    send_byte(8'h00);
`else
    expect_v(V_DONE, cyc + 1);
    send_byte(8'h00);
    send_byte(8'h00);
`endif
    idle(3);
    check_eq("t3_err_code_hold", err_code, 1);
    end_test("t3");

    // t3b: LEN == MAX_LEN accepted, bytes 01..10 (sum with LEN 0x98, csum 0x68)
    for (int i = 1; i <= 16; i++) expect_pl(8'(i), i == 16);
    send_byte(8'h7E); send_byte(8'h10);
    for (int i = 1; i <= 16; i++) begin
`ifndef UART_FRAME_CSUM_EN
      if (i == 16) expect_v(V_DONE, cyc + 1);
`endif
      send_byte(8'(i));
    end
`ifdef UART_FRAME_CSUM_EN
    expect_v(V_DONE, cyc + 1);
`endif
    send_byte(8'h68);
    idle(3);
    end_test("t3b");

    // t4: timeout after 7E 02 AA
    expect_pl(8'hAA, 0);
    send_byte(8'h7E); send_byte(8'h02);
    expect_v({2'b01, 2'd2}, cyc + T);
    send_byte(8'hAA);
    check_eq("t4_busy_wait", busy, 1);
    idle(T + 2);
    check_eq("t4_err_code", err_code, 2);
    end_test("t4");

    // t5: byte lands on the expiry cycle (02+AA+BB+99 = 0x200)
    expect_pl(8'hAA, 0); expect_pl(8'hBB, 1);
    send_byte(8'h7E); send_byte(8'h02); send_byte(8'hAA);
    idle(T - 2);
`ifndef UART_FRAME_CSUM_EN
    expect_v(V_DONE, cyc + 1);
`endif
    send_byte(8'hBB);
`ifdef UART_FRAME_CSUM_EN
    expect_v(V_DONE, cyc + 1);
`endif
    send_byte(8'h99);
    idle(T + 2);
    end_test("t5");

    // t6: noise and embedded SOF 55 7E 02 7E 7E 02
    expect_pl(8'h7E, 0); expect_pl(8'h7E, 1);
    send_byte(8'h55);
    check_eq("t6_noise_idle", busy, 0);
    send_byte(8'h7E); send_byte(8'h02); send_byte(8'h7E);
`ifndef UART_FRAME_CSUM_EN
    expect_v(V_DONE, cyc + 1);
`endif
    send_byte(8'h7E);
`ifdef UART_FRAME_CSUM_EN
    expect_v(V_DONE, cyc + 1);
`endif
    send_byte(8'h02);
    idle(3);
    end_test("t6");

    // t7: reset mid-payload, then good frame 7E 01 5A A5
    expect_pl(8'h11, 0);
    send_byte(8'h7E); send_byte(8'h03); send_byte(8'h11);
    #2 reset = 1'b1;
    #1;
    check_eq("t7_pl_valid", pl_valid, 0);
    check_eq("t7_pl_data", pl_data, 0);
    check_eq("t7_busy", busy, 0);
    check_eq("t7_state", state_dbg, 0);
    check_eq("t7_err_code", err_code, 0);
    idle(2);
    reset = 1'b0;
    idle(T + 2);
    end_test("t7a");
    expect_pl(8'h5A, 1);
    send_byte(8'h7E); send_byte(8'h01);
`ifndef UART_FRAME_CSUM_EN
    expect_v(V_DONE, cyc + 1);
`endif
    send_byte(8'h5A);
`ifdef UART_FRAME_CSUM_EN
    expect_v(V_DONE, cyc + 1);
`endif
    send_byte(8'hA5);
    idle(3);
    check_eq("t7_err_code_clean", err_code, 0);
    end_test("t7b");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
